// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: first-word-fall-through FIFO for ADC samples, with frame marking and overflow accounting.
// A push that finds the FIFO full is dropped even if a pop happens on the same edge.
module adc_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     ovf_clear
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FRAME_LEN);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [FW-1:0] LAST = FW'(FRAME_LEN-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop, drop;

  always_comb begin
    push      = in_valid && (level_q != FULL);
    drop      = in_valid && (level_q == FULL);
    out_valid = level_q != '0;
    pop       = out_valid && out_ready;
    wp_d      = push ? wp_q + AW'(1) : wp_q;
    rp_d      = pop ? rp_q + AW'(1) : rp_q;
    level_d   = (push && !pop) ? level_q + (AW+1)'(1) :
                (pop && !push) ? level_q - (AW+1)'(1) : level_q;
    frame_d   = !pop ? frame_q : (frame_q == LAST) ? '0 : frame_q + FW'(1);
    // A drop outranks a coincident clear so the new event is never lost.
    ovf_d     = drop || (ovf_q && !ovf_clear);
    drop_d    = drop ? (ovf_clear ? 8'd1 : (drop_q == 8'hff) ? 8'hff : drop_q + 8'd1) :
                ovf_clear ? 8'd0 : drop_q;
  end

  always_ff @(posedge clk) if (push) mem[wp_q] <= in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data   = mem[rp_q];
  assign out_last   = out_valid && (frame_q == LAST);
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: directed and random stimulus checked against a queue-based model of the FIFO.
module tb_adc_sample_fifo;
  localparam int DW = 16, DEPTH = 16, FL = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] in_data = '0, out_data;
  logic          in_valid = 1'b0, out_ready = 1'b0, ovf_clear = 1'b0;
  logic          out_valid, out_last, overflow;
  logic [4:0]    level;
  logic [7:0]    drop_count;

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] q [$];
  int pops = 0, m_drops = 0;
  bit m_ovf = 0;

  adc_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .level(level), .overflow(overflow),
    .drop_count(drop_count), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", int'(level), q.size());
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("out_last", int'(out_last), int'(q.size() > 0 && pops % FL == FL - 1));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("drop_count", int'(drop_count), m_drops);
    if (q.size() > 0) chk("out_data", int'(out_data), int'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    pops = 0;
    m_ovf = 0;
    m_drops = 0;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy, input bit clr);
    int n;
    in_valid = v; in_data = d; out_ready = rdy; ovf_clear = clr;
    @(posedge clk);
    n = q.size();
    if (n > 0 && rdy) begin
      void'(q.pop_front());
      pops++;
    end
    if (v && n < DEPTH) q.push_back(d);
    if (v && n == DEPTH) begin
      m_ovf = 1;
      m_drops = clr ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 0;
      m_drops = 0;
    end
    #1 check_all();
  endtask

  task automatic pulse_reset();
    in_valid = 0; out_ready = 0; ovf_clear = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_last", int'(out_last), 0);
    #1 rst_n = 1;
    model_reset();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1;
    #6;
    // single push into empty FIFO falls through next cycle
    step(1, 16'h1234, 0, 0);
    chk("fwft_data", int'(out_data), 32'h1234);
    chk("fwft_level", int'(level), 1);
    step(0, 0, 1, 0);
    // overfill: 20 pushes into 16 slots
    for (int i = 0; i < 20; i++) step(1, DW'(i), 0, 0);
    chk("full_level", int'(level), 16);
    chk("full_drops", int'(drop_count), 4);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", int'(out_data), i);
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 1);
    // steady push/pop at level 8
    for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 100; i++) step(1, DW'($urandom), 1, 0);
    chk("steady_level", int'(level), 8);
    chk("steady_drops", int'(drop_count), 0);
    // frame marking with stalls
    pulse_reset();
    for (int i = 0; i < 12; i++) step(1, DW'(100 + i), 0, 0);
    for (int i = 0; i < 200 && q.size() > 0; i++) step(0, 0, 1'($urandom_range(0, 1)), 0);
    chk("frame_pops", pops, 12);
    // clear coincident with drop, then saturation
    pulse_reset();
    for (int i = 0; i < 23; i++) step(1, DW'(i), 0, 0);
    chk("drops7", int'(drop_count), 7);
    step(1, 0, 0, 1);
    chk("clr_drop_cnt", int'(drop_count), 1);
    chk("clr_drop_ovf", int'(overflow), 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0);
    chk("sat", int'(drop_count), 255);
    // reset mid-operation at level 5
    pulse_reset();
    for (int i = 0; i < 5; i++) step(1, DW'(i), 0, 0);
    chk("lvl5", int'(level), 5);
    pulse_reset();
    step(1, 16'hbeef, 0, 0);
    chk("post_rst_head", int'(out_data), 32'hbeef);
    step(0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 40) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
